// File: rtl/bram_dp_ctrl.sv
// bram_dp_ctrl: simple dual-port RAM with clear sweep, byte masks, 1/2-cycle read latency; BRAM_PARITY_EN adds per-word parity
module bram_dp_ctrl #(
  parameter int NB_ADDR = 10,
  parameter int NB_DATA = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE = 0,
  parameter logic [NB_DATA-1:0] CLR_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_write_enable,
  input  logic [NB_ADDR-1:0]   i_write_addr,
  input  logic [NB_DATA/8-1:0] i_write_mask,
  input  logic [NB_DATA-1:0]   i_data,
  input  logic                 i_read_enable,
  input  logic [NB_ADDR-1:0]   i_read_addr,
  output logic [NB_DATA-1:0]   o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_parity_err
);
  localparam int DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_ADDR:0] LAST = (NB_ADDR + 1)'(DEPTH - 1);
  localparam logic ST_READY = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  logic                 state_q, state_d;
  logic [NB_ADDR:0]     cnt_q, cnt_d;
  logic [NB_DATA-1:0]   mem [DEPTH];
  logic [NB_DATA-1:0]   wr_old, wr_new, rd_word, mem_wdata;
  logic [NB_ADDR-1:0]   mem_waddr;
  logic                 busy, we, re, hit, mem_we, rd_err;
  logic [NB_DATA-1:0]   d1_q, d2_q;
  logic                 v1_q, v2_q, e1_q, e2_q;

  assign busy = state_q == ST_CLEAR;
  assign we = i_write_enable & ~busy;
  assign re = i_read_enable & ~busy;
  assign hit = we && i_write_addr == i_read_addr;
  assign wr_old = mem[i_write_addr];
  assign rd_word = (RDW_MODE == 1 && hit) ? wr_new : mem[i_read_addr];
  assign mem_we = busy | (we & |i_write_mask);
  assign mem_waddr = busy ? cnt_q[NB_ADDR-1:0] : i_write_addr;
  assign mem_wdata = busy ? CLR_VALUE : wr_new;

  // Byte-merge the write data into the currently stored word
  always_comb begin
    wr_new = wr_old;
    for (int k = 0; k < NB_DATA / 8; k++)
      wr_new[8*k +: 8] = i_write_mask[k] ? i_data[8*k +: 8] : wr_old[8*k +: 8];
  end

  // Sweep sequencing: count through every address, then wait for the next clear request
  always_comb begin
    state_d = busy ? (cnt_q == LAST ? ST_READY : ST_CLEAR) : (i_clear ? ST_CLEAR : ST_READY);
    cnt_d = busy ? cnt_q + 1'b1 : '0;
  end

  // FSM state and sweep counter; reset restarts the sweep from address 0
  always_ff @(posedge clock or posedge i_reset)
    if (i_reset) begin
      state_q <= ST_CLEAR;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end

  // Storage array; shared by the sweep and the user write port, never reset
  always_ff @(posedge clock)
    if (mem_we) mem[mem_waddr] <= mem_wdata;

`ifdef BRAM_PARITY_EN
  logic par_mem [DEPTH];
  // Even-parity bit kept alongside every stored word, sweep writes included
  always_ff @(posedge clock)
    if (mem_we) par_mem[mem_waddr] <= ^mem_wdata;
  assign rd_err = ^rd_word ^ ((RDW_MODE == 1 && hit) ? ^wr_new : par_mem[i_read_addr]);
`else
  assign rd_err = 1'b0;
`endif

  // Read pipeline: stage 1 always, stage 2 selected for two-cycle latency; data held between reads
  always_ff @(posedge clock or posedge i_reset)
    if (i_reset) begin
      d1_q <= '0;
      d2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      e1_q <= 1'b0;
      e2_q <= 1'b0;
    end else begin
      v1_q <= re;
      e1_q <= re & rd_err;
      if (re) d1_q <= rd_word;
      v2_q <= v1_q;
      e2_q <= e1_q;
      if (v1_q) d2_q <= d1_q;
    end

  assign o_data = RD_LATENCY == 2 ? d2_q : d1_q;
  assign o_valid = RD_LATENCY == 2 ? v2_q : v1_q;
  assign o_parity_err = RD_LATENCY == 2 ? e2_q : e1_q;
  assign o_busy = busy;
endmodule

// File: tb/tb_bram_dp_ctrl.sv
// tb_bram_dp_ctrl: directed checks on a latency-1/old-data and a latency-2/new-data instance driven in parallel
module tb_bram_dp_ctrl;
  logic clock = 1'b0;
  logic i_reset, i_clear, i_write_enable, i_read_enable;
  logic [3:0] i_write_addr, i_read_addr;
  logic [1:0] i_write_mask;
  logic [15:0] i_data;
  logic [15:0] a_data, b_data;
  logic a_valid, a_busy, a_perr, b_valid, b_busy, b_perr;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  bram_dp_ctrl #(.NB_ADDR(4), .NB_DATA(16), .RD_LATENCY(1), .RDW_MODE(0), .CLR_VALUE(16'hA5A5)) dut_a (
    .clock(clock), .i_reset(i_reset), .i_clear(i_clear), .i_write_enable(i_write_enable),
    .i_write_addr(i_write_addr), .i_write_mask(i_write_mask), .i_data(i_data),
    .i_read_enable(i_read_enable), .i_read_addr(i_read_addr),
    .o_data(a_data), .o_valid(a_valid), .o_busy(a_busy), .o_parity_err(a_perr));

  bram_dp_ctrl #(.NB_ADDR(4), .NB_DATA(16), .RD_LATENCY(2), .RDW_MODE(1), .CLR_VALUE(16'hA5A5)) dut_b (
    .clock(clock), .i_reset(i_reset), .i_clear(i_clear), .i_write_enable(i_write_enable),
    .i_write_addr(i_write_addr), .i_write_mask(i_write_mask), .i_data(i_data),
    .i_read_enable(i_read_enable), .i_read_addr(i_read_addr),
    .o_data(b_data), .o_valid(b_valid), .o_busy(b_busy), .o_parity_err(b_perr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    i_write_enable = 1'b1;
    i_write_addr = a;
    i_data = d;
    i_write_mask = m;
    step;
    i_write_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb, input logic ep);
    i_read_enable = 1'b1;
    i_read_addr = a;
    step;
    i_read_enable = 1'b0;
    chk({tag, "_a"}, {a_perr, a_valid, a_data}, {ep, 1'b1, ea});
    chk({tag, "_b_early"}, b_valid, 0);
    step;
    chk({tag, "_b"}, {b_perr, b_valid, b_data}, {ep, 1'b1, eb});
    chk({tag, "_a_done"}, a_valid, 0);
  endtask

  task automatic sweep_len(input string tag);
    int n = 0;
    int vseen = 0;
    while (a_busy && n < 100) begin
      if (a_valid || b_valid || a_busy !== b_busy) vseen++;
      n++;
      step;
    end
    i_clear = 1'b0;
    i_write_enable = 1'b0;
    i_read_enable = 1'b0;
    chk({tag, "_len"}, n, 16);
    chk({tag, "_quiet"}, vseen, 0);
    chk({tag, "_b_ready"}, b_busy, 0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_clear = 1'b0;
    i_write_enable = 1'b0;
    i_read_enable = 1'b0;
    i_write_addr = '0;
    i_read_addr = '0;
    i_write_mask = '0;
    i_data = '0;
    repeat (2) step;
    chk("rst_busy", {a_busy, b_busy}, 2'b11);
    chk("rst_valid", {a_valid, b_valid}, 2'b00);
    chk("rst_data", {a_data, b_data}, 32'h0);
    chk("rst_perr", {a_perr, b_perr}, 2'b00);
    i_reset = 1'b0;
    sweep_len("sweep1");
    for (int i = 0; i <= 16; i++) begin
      i_read_enable = i < 16;
      i_read_addr = 4'(i);
      step;
      if (i < 16) chk("seq_a", {a_valid, a_data}, {1'b1, 16'hA5A5});
      if (i >= 1) chk("seq_b", {b_valid, b_data}, {1'b1, 16'hA5A5});
    end
    i_read_enable = 1'b0;
    step;
    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hFFFF, 2'b01);
    rd("mask_lo", 4'd3, 16'h12FF, 16'h12FF, 1'b0);
    wr(4'd4, 16'h0000, 2'b00);
    rd("mask_none", 4'd4, 16'hA5A5, 16'hA5A5, 1'b0);
    wr(4'd6, 16'hBEEF, 2'b10);
    rd("mask_hi", 4'd6, 16'hBEA5, 16'hBEA5, 1'b0);
    i_write_enable = 1'b1;
    i_write_addr = 4'd5;
    i_data = 16'h0F0F;
    i_write_mask = 2'b11;
    i_read_enable = 1'b1;
    i_read_addr = 4'd5;
    step;
    i_write_enable = 1'b0;
    i_read_enable = 1'b0;
    chk("rdw_old", {a_valid, a_data}, {1'b1, 16'hA5A5});
    step;
    chk("rdw_new", {b_valid, b_data}, {1'b1, 16'h0F0F});
    rd("rdw_after", 4'd5, 16'h0F0F, 16'h0F0F, 1'b0);
    wr(4'd1, 16'h1111, 2'b11);
    wr(4'd2, 16'h2222, 2'b11);
    i_read_enable = 1'b1;
    i_read_addr = 4'd1;
    step;
    chk("pipe1_a", {a_valid, a_data}, {1'b1, 16'h1111});
    chk("pipe1_b", b_valid, 0);
    i_read_addr = 4'd2;
    step;
    chk("pipe2_a", {a_valid, a_data}, {1'b1, 16'h2222});
    chk("pipe2_b", {b_valid, b_data}, {1'b1, 16'h1111});
    i_read_addr = 4'd3;
    step;
    chk("pipe3_a", {a_valid, a_data}, {1'b1, 16'h12FF});
    chk("pipe3_b", {b_valid, b_data}, {1'b1, 16'h2222});
    i_read_enable = 1'b0;
    step;
    chk("pipe4_a_hold", {a_valid, a_data}, {1'b0, 16'h12FF});
    chk("pipe4_b", {b_valid, b_data}, {1'b1, 16'h12FF});
    step;
    chk("pipe5_b_hold", {b_valid, b_data}, {1'b0, 16'h12FF});
    i_clear = 1'b1;
    i_read_enable = 1'b1;
    i_read_addr = 4'd3;
    step;
    i_clear = 1'b0;
    i_read_enable = 1'b0;
    chk("clr_busy", {a_busy, b_busy}, 2'b11);
    chk("clr_rd_a", {a_valid, a_data}, {1'b1, 16'h12FF});
    step;
    chk("clr_rd_b", {b_valid, b_data}, {1'b1, 16'h12FF});
    repeat (6) step;
    i_reset = 1'b1;
    step;
    chk("rst2_busy", {a_busy, b_busy}, 2'b11);
    chk("rst2_data", {a_valid, a_data, b_valid, b_data}, 34'h0);
    i_write_enable = 1'b1;
    i_write_addr = 4'd1;
    i_data = 16'h7777;
    i_write_mask = 2'b11;
    i_read_enable = 1'b1;
    i_read_addr = 4'd1;
    i_clear = 1'b1;
    i_reset = 1'b0;
    sweep_len("sweep2");
    rd("lost_wr", 4'd1, 16'hA5A5, 16'hA5A5, 1'b0);
    rd("recleared", 4'd3, 16'hA5A5, 16'hA5A5, 1'b0);
`ifdef BRAM_PARITY_EN
    dut_a.mem[9] = dut_a.mem[9] ^ 16'h0001;
    dut_b.mem[9] = dut_b.mem[9] ^ 16'h0001;
    rd("par_bad", 4'd9, 16'hA5A4, 16'hA5A4, 1'b1);
`else
    rd("par_none", 4'd9, 16'hA5A5, 16'hA5A5, 1'b0);
`endif
    rd("par_ok", 4'd8, 16'hA5A5, 16'hA5A5, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
